bk_memory_initiator: RTL and testbench

- Initiator/master side of the bkMemory port: accepts single or burst load/store requests from the core and sequences memoryRead/memoryWrite, memoryAddress and memoryWriteData toward the 256-entry RAM bank.
- Captures memoryOutData into a registered response stream with ready/valid backpressure.
- Sits between the processor load/store path and the bkMemory instance.

---
 rtl/bk_memory_initiator_if.sv | 33 +++
 rtl/bk_memory_initiator.sv | 72 +++++++
 tb/tb_bk_memory_initiator.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bk_memory_initiator_if.sv
// bk_memory_initiator_if: request, write-data, response and RAM-side signals of the bkMemory initiator
//   master: initiator view (takes requests, write beats and resp_ready, drives the RAM strobes)
//   slave : core/RAM view (mirror of master)
interface bk_memory_initiator_if #(parameter int WIDTH = 8);
    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [WIDTH-1:0]   req_address;
    logic [WIDTH-1:0]   req_length;
    logic               wr_valid;
    logic [2*WIDTH-1:0] wr_data;
    logic               wr_ready;
    logic               wr_done;
    logic               resp_valid;
    logic [2*WIDTH-1:0] resp_data;
    logic               resp_last;
    logic               resp_ready;
    logic               memory_read;
    logic               memory_write;
    logic [WIDTH-1:0]   memory_address;
    logic [2*WIDTH-1:0] memory_write_data;
    logic [2*WIDTH-1:0] memory_out_data;
    modport master (
        input  req_valid, req_write, req_address, req_length, wr_valid, wr_data, resp_ready, memory_out_data,
        output req_ready, wr_ready, wr_done, resp_valid, resp_data, resp_last,
               memory_read, memory_write, memory_address, memory_write_data
    );
    modport slave (
        output req_valid, req_write, req_address, req_length, wr_valid, wr_data, resp_ready, memory_out_data,
        input  req_ready, wr_ready, wr_done, resp_valid, resp_data, resp_last,
               memory_read, memory_write, memory_address, memory_write_data
    );
endinterface

// File: rtl/bk_memory_initiator.sv
// bk_memory_initiator: sequences single/burst load/store requests onto a 256-entry bkMemory bank
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : request / write-data / response streams and RAM strobes (master modport)
module bk_memory_initiator #(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    bk_memory_initiator_if.master         bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_cur_addr;
    logic [WIDTH-1:0]   r_beats_left;
    logic [2*WIDTH-1:0] r_resp_data;
    logic               r_resp_valid;
    logic               r_resp_last;
    logic               r_wr_done;
    logic               w_issue;
    logic               w_wr_beat;
    logic               w_accept;
    logic               w_last;
    // strobes are gated by rst so a reset edge never commits a RAM access
    assign w_issue   = (r_state == READ) && (!r_resp_valid || bus.resp_ready) && !rst;
    assign w_wr_beat = (r_state == WRITE) && bus.wr_valid && !rst;
    assign w_accept  = bus.req_valid && bus.req_ready;
    assign w_last    = r_beats_left == '0;
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE && w_accept) ? (bus.req_write ? WRITE : READ) :
                 ((w_issue || w_wr_beat) && w_last) ? IDLE : r_state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cur_addr   <= '0;
            r_beats_left <= '0;
            r_resp_data  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_last  <= 1'b0;
            r_wr_done    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_wr_done <= w_wr_beat && w_last;
            if (w_accept) begin
                r_cur_addr   <= bus.req_address;
                r_beats_left <= bus.req_length;
            end else if (w_issue || w_wr_beat) begin
                r_cur_addr   <= r_cur_addr + 1'b1;
                r_beats_left <= r_beats_left - 1'b1;
            end
            if (w_issue) begin
                r_resp_data  <= bus.memory_out_data;
                r_resp_valid <= 1'b1;
                r_resp_last  <= w_last;
            end else if (bus.resp_ready) begin
                r_resp_valid <= 1'b0;
            end
        end
    end
    assign bus.req_ready         = (r_state == IDLE) && !r_resp_valid && !rst;
    assign bus.wr_ready          = r_state == WRITE;
    assign bus.wr_done           = r_wr_done;
    assign bus.resp_valid        = r_resp_valid;
    assign bus.resp_data         = r_resp_data;
    assign bus.resp_last         = r_resp_last;
    assign bus.memory_read       = w_issue;
    assign bus.memory_write      = w_wr_beat;
    assign bus.memory_address    = r_cur_addr;
    assign bus.memory_write_data = r_state == WRITE ? bus.wr_data : '0;
endmodule

// File: tb/tb_bk_memory_initiator.sv
// tb_bk_memory_initiator: directed checks of the bkMemory initiator against a 256-word RAM model
module tb_bk_memory_initiator;
    logic clk = 1'b0;
    logic rst;
    int n_chk = 0;
    int n_err = 0;
    logic [15:0] mem [256];
    logic [15:0] exp_w [4];
    bk_memory_initiator_if #(.WIDTH(8)) bus ();
    bk_memory_initiator #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus.master));
    always #5 clk = ~clk;
    assign bus.memory_out_data = mem[bus.memory_address];
    always @(posedge clk) if (bus.memory_write) mem[bus.memory_address] <= bus.memory_write_data;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333; exp_w[3] = 16'h4444;
        rst = 1'b1;
        bus.req_valid = 0; bus.req_write = 0; bus.req_address = 0; bus.req_length = 0;
        bus.wr_valid = 0; bus.wr_data = 0; bus.resp_ready = 0;
        cyc(); cyc();
        #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_mem_addr", bus.memory_address, 0);
        rst = 1'b0;
        #1;
        chk("idle_req_ready", bus.req_ready, 1);
        chk("idle_wr_ready", bus.wr_ready, 0);
        // single write of BEEF at 0x10
        bus.req_valid = 1; bus.req_write = 1; bus.req_address = 8'h10; bus.req_length = 0;
        cyc();
        bus.req_valid = 0; bus.wr_valid = 1; bus.wr_data = 16'hBEEF;
        #1;
        chk("w1_wr_ready", bus.wr_ready, 1);
        chk("w1_mem_write", bus.memory_write, 1);
        chk("w1_mem_read", bus.memory_read, 0);
        chk("w1_addr", bus.memory_address, 8'h10);
        chk("w1_wdata", bus.memory_write_data, 16'hBEEF);
        cyc();
        bus.wr_valid = 0;
        #1;
        chk("w1_wr_done", bus.wr_done, 1);
        chk("w1_no_write", bus.memory_write, 0);
        chk("w1_wdata_idle", bus.memory_write_data, 0);
        chk("w1_req_ready", bus.req_ready, 1);
        cyc();
        #1;
        chk("w1_wr_done_clr", bus.wr_done, 0);
        chk("w1_ram", mem[8'h10], 16'hBEEF);
        // single read at 0x10
        bus.req_valid = 1; bus.req_write = 0; bus.req_address = 8'h10; bus.req_length = 0;
        cyc();
        bus.req_valid = 0;
        #1;
        chk("r1_mem_read", bus.memory_read, 1);
        chk("r1_addr", bus.memory_address, 8'h10);
        chk("r1_resp_valid0", bus.resp_valid, 0);
        cyc();
        #1;
        chk("r1_resp_valid", bus.resp_valid, 1);
        chk("r1_resp_data", bus.resp_data, 16'hBEEF);
        chk("r1_resp_last", bus.resp_last, 1);
        chk("r1_no_read", bus.memory_read, 0);
        chk("r1_req_ready_busy", bus.req_ready, 0);
        bus.resp_ready = 1;
        cyc();
        bus.resp_ready = 0;
        #1;
        chk("r1_resp_clr", bus.resp_valid, 0);
        chk("r1_req_ready", bus.req_ready, 1);
        // write burst wrapping 0xFE..0x01
        bus.req_valid = 1; bus.req_write = 1; bus.req_address = 8'hFE; bus.req_length = 3;
        cyc();
        bus.req_valid = 0;
        for (int k = 0; k < 4; k++) begin
            bus.wr_valid = 1; bus.wr_data = exp_w[k];
            #1;
            chk("wb_mem_write", bus.memory_write, 1);
            chk("wb_addr", bus.memory_address, 32'((8'hFE + k) & 8'hFF));
            chk("wb_wr_done", bus.wr_done, 0);
            cyc();
        end
        bus.wr_valid = 0;
        #1;
        chk("wb_wr_done", bus.wr_done, 1);
        chk("wb_ram_00", mem[8'h00], 16'h3333);
        chk("wb_ram_ff", mem[8'hFF], 16'h2222);
        cyc();
        // read-back burst at full throughput
        bus.req_valid = 1; bus.req_write = 0; bus.req_address = 8'hFE; bus.req_length = 3; bus.resp_ready = 1;
        cyc();
        bus.req_valid = 0;
        #1;
        chk("rb_issue0", bus.memory_read, 1);
        chk("rb_addr0", bus.memory_address, 8'hFE);
        cyc();
        for (int k = 1; k < 4; k++) begin
            #1;
            chk("rb_data", bus.resp_data, exp_w[k-1]);
            chk("rb_last", bus.resp_last, 0);
            chk("rb_addr", bus.memory_address, 32'((8'hFE + k) & 8'hFF));
            chk("rb_issue", bus.memory_read, 1);
            cyc();
        end
        #1;
        chk("rb_data_last", bus.resp_data, 16'h4444);
        chk("rb_last_flag", bus.resp_last, 1);
        chk("rb_done_read", bus.memory_read, 0);
        cyc();
        #1;
        chk("rb_resp_clr", bus.resp_valid, 0);
        // read burst with 3-cycle consumer stall after the first beat
        bus.resp_ready = 0;
        bus.req_valid = 1; bus.req_write = 0; bus.req_address = 8'hFE; bus.req_length = 3;
        cyc();
        bus.req_valid = 0;
        #1;
        chk("rs_issue0", bus.memory_read, 1);
        cyc();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("rs_stall_read", bus.memory_read, 0);
            chk("rs_stall_data", bus.resp_data, 16'h1111);
            chk("rs_stall_valid", bus.resp_valid, 1);
            cyc();
        end
        bus.resp_ready = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rs_valid", bus.resp_valid, 1);
            chk("rs_data", bus.resp_data, exp_w[k]);
            chk("rs_last", bus.resp_last, 32'(k == 3));
            cyc();
        end
        #1;
        chk("rs_resp_clr", bus.resp_valid, 0);
        bus.resp_ready = 0;
        // write burst of 3 with a 2-cycle wr_valid gap
        bus.req_valid = 1; bus.req_write = 1; bus.req_address = 8'h20; bus.req_length = 2;
        cyc();
        bus.req_valid = 0;
        for (int k = 0; k < 2; k++) begin
            bus.wr_valid = 1; bus.wr_data = 16'hA1 + 16'(k);
            #1;
            chk("wg_write", bus.memory_write, 1);
            chk("wg_addr", bus.memory_address, 32'(8'h20 + k));
            cyc();
        end
        bus.wr_valid = 0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("wg_gap_write", bus.memory_write, 0);
            chk("wg_gap_done", bus.wr_done, 0);
            chk("wg_gap_addr", bus.memory_address, 8'h22);
            cyc();
        end
        bus.wr_valid = 1; bus.wr_data = 16'hA3;
        #1;
        chk("wg_write3", bus.memory_write, 1);
        chk("wg_done_early", bus.wr_done, 0);
        cyc();
        bus.wr_valid = 0;
        #1;
        chk("wg_wr_done", bus.wr_done, 1);
        chk("wg_ram", mem[8'h22], 16'hA3);
        cyc();
        #1;
        chk("wg_wr_done_clr", bus.wr_done, 0);
        // reset in the middle of a 4-beat write
        bus.req_valid = 1; bus.req_write = 1; bus.req_address = 8'h00; bus.req_length = 3;
        cyc();
        bus.req_valid = 0;
        for (int k = 0; k < 2; k++) begin
            bus.wr_valid = 1; bus.wr_data = 16'h5555 + 16'(k) * 16'h1111;
            cyc();
        end
        rst = 1; bus.wr_data = 16'h7777;
        #1;
        chk("rm_no_write", bus.memory_write, 0);
        cyc();
        rst = 0; bus.wr_valid = 0;
        #1;
        chk("rm_req_ready", bus.req_ready, 1);
        chk("rm_wr_ready", bus.wr_ready, 0);
        chk("rm_wr_done", bus.wr_done, 0);
        cyc();
        #1;
        chk("rm_wr_done2", bus.wr_done, 0);
        chk("rm_ram1", mem[8'h01], 16'h6666);
        chk("rm_ram2", mem[8'h02], 16'h0000);
        chk("rm_ram3", mem[8'h03], 16'h0000);
        // request held high during an active read burst
        bus.req_valid = 1; bus.req_write = 0; bus.req_address = 8'h20; bus.req_length = 2; bus.resp_ready = 1;
        cyc();
        bus.req_address = 8'h10; bus.req_length = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("rh_req_ready", bus.req_ready, 0);
            chk("rh_addr", bus.memory_address, 32'(8'h20 + k));
            if (k > 0) chk("rh_data", bus.resp_data, 32'(16'hA1 + k - 1));
            cyc();
        end
        bus.resp_ready = 0;
        #1;
        chk("rh_data_last", bus.resp_data, 16'hA3);
        chk("rh_last", bus.resp_last, 1);
        chk("rh_req_ready_pend", bus.req_ready, 0);
        cyc();
        #1;
        chk("rh_req_ready_hold", bus.req_ready, 0);
        chk("rh_valid_hold", bus.resp_valid, 1);
        bus.resp_ready = 1;
        cyc();
        #1;
        chk("rh_req_ready_free", bus.req_ready, 1);
        cyc();
        bus.req_valid = 0;
        #1;
        chk("rh_second_issue", bus.memory_read, 1);
        chk("rh_second_addr", bus.memory_address, 8'h10);
        cyc();
        #1;
        chk("rh_second_data", bus.resp_data, 16'hBEEF);
        chk("rh_second_last", bus.resp_last, 1);
        cyc();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
